register_crypt_serial: RTL
==========================

Name: register_crypt_serial

Overview:
- Operand register for the RSA bit-serial Montgomery datapath. Generalises the single-word enable/clear/load register.
- Loads an operand in one of two ways: one parallel word, or CHUNK-wide pieces over a valid/ready write port.
- Shifts the operand out LSB-first, one bit per shift request, tracking the remaining bits.
- Signals completion to the multiplier sequencer with a one-cycle done pulse.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of CHUNK and at least 2*CHUNK.
- CHUNK, 8, width of the write port in bits.

Ports:
- clk  input  1  rising-edge clock
- rstb  input  1  reset, synchronous, active-low
- ena  input  1  global enable; when low, all state is held
- clear  input  1  synchronous clear, active-low; sets state to empty/IDLE
- load  input  1  parallel load of R_i
- R_i  input  WIDTH  parallel operand
- wr_valid  input  1  chunk write request
- wr_data  input  CHUNK  chunk data; least-significant chunk is written first
- wr_ready  output  1  chunk can be accepted
- shift  input  1  request to shift one bit out
- C_ex  output  WIDTH  register contents
- bit_o  output  1  current LSB, equal to C_ex[0] (combinational from the register)
- full  output  1  operand loaded and not fully consumed
- bits_left  output  $clog2(WIDTH+1)  bits not yet shifted out
- done  output  1  one-cycle pulse after the last bit is consumed

Behaviour:
- State machine states: IDLE, FILL, READY.
- Reset (rstb low at a clk edge): C_ex=0, state=IDLE, chunk_cnt=0, bits_left=0, full=0, done=0, wr_ready=1.
- Rising-edge priority: rstb, then ena low, then clear low, then load, then write handshake, then shift.
- ena low: every register holds its value, including done (no new pulse is generated). wr_ready is forced to 0.
- clear low (with ena high): same end state as reset, from any state. Clearing mid-fill or mid-shift aborts with no done pulse.
- load high: C_ex<=R_i, bits_left<=WIDTH, chunk_cnt<=0, state<=READY. Accepted from any state and overrides a concurrent wr_valid or shift.
- wr_ready is 1 in IDLE and FILL (with ena high) and 0 in READY.
- Write handshake is wr_valid && wr_ready:
  - C_ex <= {wr_data, C_ex[WIDTH-1:CHUNK]} (shift right by CHUNK, new chunk enters at the top).
  - chunk_cnt increments; state goes IDLE->FILL on the first accepted chunk.
  - On the chunk that makes chunk_cnt reach WIDTH/CHUNK: state<=READY, bits_left<=WIDTH, chunk_cnt<=0.
- wr_valid in READY is ignored; no data is lost from C_ex.
- shift in READY: C_ex is shifted right by 1 with 0 into the MSB, and bits_left decrements.
  - When bits_left goes 1->0: state<=IDLE and done=1 for exactly one cycle (registered, visible the cycle after the final shift edge).
- shift in IDLE or FILL is ignored.
- full = (state==READY). done is 0 in every cycle except the pulse cycle.
- A load in the same cycle as the final shift: load wins, no done, READY with the new operand.

Optional Feature:
- Macro: REGISTER_CRYPT_ROTATE_EN.
- Defined: shift rotates instead of zero-filling, so C_ex[0] enters the MSB. After WIDTH shifts, C_ex equals the originally loaded operand; state is IDLE and done pulses as normal.
- Not defined: zero-fill shift, so C_ex=0 after WIDTH shifts.

Test Plan (WIDTH=32, CHUNK=8):
1. Reset: rstb=0 for one edge from a random state -> C_ex=0, full=0, bits_left=0, wr_ready=1, done=0.
2. Chunk fill: writes 0x78, 0x56, 0x34, 0x12 -> C_ex=0x12345678, full=1, bits_left=32, wr_ready=0. A fifth write of 0xFF is ignored and C_ex is unchanged.
3. Shift-out: after test 2, 32 shift pulses -> bit_o sequence equals 0x12345678 LSB-first, bits_left counts 32->0, and done pulses once. C_ex=0, or 0x12345678 with REGISTER_CRYPT_ROTATE_EN.
4. Mid-shift clear: load R_i=0xDEADBEEF, shift 5 times, then clear=0 -> C_ex=0, IDLE, bits_left=0, no done pulse.
5. ena hold: ena=0 with wr_valid=1, shift=1 and load=1 for 4 cycles -> C_ex, bits_left and state are unchanged, and wr_ready=0.
6. Priority: load=1 with R_i=0xCAFEF00D and wr_valid=1 in FILL (2 chunks accepted) -> C_ex=0xCAFEF00D, READY, chunk_cnt=0. Then load coincident with the final shift -> no done, bits_left=32.

Source files
------------

// File: rtl/register_crypt_serial.sv
// register_crypt_serial: operand register with parallel/chunked load and LSB-first bit-serial shift-out.
// Define REGISTER_CRYPT_ROTATE_EN to make shifts rotate (C_ex[0] re-enters at the MSB) instead of zero-filling.
module register_crypt_serial #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic                       clk,
  input  logic                       rstb,
  input  logic                       ena,
  input  logic                       clear,
  input  logic                       load,
  input  logic [WIDTH-1:0]           R_i,
  input  logic                       wr_valid,
  input  logic [CHUNK-1:0]           wr_data,
  output logic                       wr_ready,
  input  logic                       shift,
  output logic [WIDTH-1:0]           C_ex,
  output logic                       bit_o,
  output logic                       full,
  output logic [$clog2(WIDTH+1)-1:0] bits_left,
  output logic                       done
);
  localparam int BW = $clog2(WIDTH + 1);
  localparam int NC = WIDTH / CHUNK;
  localparam int CW = $clog2(NC + 1);
  typedef enum logic [1:0] {IDLE, FILL, READY} state_t;
  state_t          state_q;
  logic [WIDTH-1:0] c_q;
  logic [BW-1:0]    bits_q;
  logic [CW-1:0]    cnt_q;
  logic             done_q;
  logic             fill_d;
`ifdef REGISTER_CRYPT_ROTATE_EN
  assign fill_d = c_q[0];
`else
  assign fill_d = 1'b0;
`endif
  assign wr_ready  = ena && state_q != READY;
  assign C_ex      = c_q;
  assign bit_o     = c_q[0];
  assign full      = state_q == READY;
  assign bits_left = bits_q;
  assign done      = done_q;
  // done defaults low whenever enabled, so it is a single-cycle pulse; ena low holds it.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      c_q     <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      bits_q  <= '0;
      done_q  <= 1'b0;
    end else if (ena) begin
      done_q <= 1'b0;
      if (!clear) begin
        c_q     <= '0;
        state_q <= IDLE;
        cnt_q   <= '0;
        bits_q  <= '0;
      end else if (load) begin
        c_q     <= R_i;
        bits_q  <= BW'(WIDTH);
        cnt_q   <= '0;
        state_q <= READY;
      end else if (wr_valid && state_q != READY) begin
        c_q <= {wr_data, c_q[WIDTH-1:CHUNK]};
        if (cnt_q == CW'(NC - 1)) begin
          state_q <= READY;
          bits_q  <= BW'(WIDTH);
          cnt_q   <= '0;
        end else begin
          state_q <= FILL;
          cnt_q   <= cnt_q + 1'b1;
        end
      end else if (shift && state_q == READY) begin
        c_q    <= {fill_d, c_q[WIDTH-1:1]};
        bits_q <= bits_q - 1'b1;
        if (bits_q == BW'(1)) begin
          state_q <= IDLE;
          done_q  <= 1'b1;
        end
      end
    end
  end
endmodule
